fwd_hazard_ctrl: RTL
====================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Parametrised forwarding + hazard controller for the RISC-V Lite pipeline.
//  Selects operand bypass sources for the EX stage over NUM_SRC younger stages, youngest first.
//  Detects load-use hazards in ID and holds the pipeline for LOAD_LAT cycles via a small FSM.
//  Freezes the whole pipeline on data-memory wait states and counts stall cycles for perf.
// PARAMETERS
//  REG_AW    5   register address width
//  NUM_SRC   2   forwarding sources; index 0 = EX/MEM (youngest), NUM_SRC-1 = oldest WB-side
//  LOAD_LAT  1   bubble cycles inserted on a load-use hazard (1..7)
//  CNT_W     32  width of stall performance counter
// PORTS
//  clk            in   1               rising-edge clock
//  rst_n          in   1               asynchronous active-low reset
//  id_rs1/id_rs2  in   REG_AW          source regs of instruction in ID
//  id_rs_used     in   2               [0]=rs1 read, [1]=rs2 read by ID instruction
//  ex_rs1/ex_rs2  in   REG_AW          source regs of instruction in EX
//  ex_alu_src     in   2               [0]=1: operand A not a register; [1]=1: operand B not a register
//  ex_rd          in   REG_AW          destination of instruction in EX
//  ex_is_load     in   1               EX instruction is a load with regwrite
//  src_rd         in   NUM_SRC*REG_AW  packed rd of each forwarding source
//  src_regwrite   in   NUM_SRC         regwrite of each forwarding source
//  mem_busy       in   1               data memory not ready this cycle
//  flush          in   1               taken branch/jump: kill IF/ID contents
//  fwd_a/fwd_b    out  FSEL_W          0 = no forward, k = source k-1 (FSEL_W=$clog2(NUM_SRC+1))
//  stall_fe       out  1               hold PC and IF/ID register
//  bubble_ex      out  1               zero control bits into ID/EX
//  freeze_all     out  1               hold every pipeline register
//  stall_cnt      out  CNT_W           saturating count of cycles with stall_fe|freeze_all
// BEHAVIOUR
//  Reset: FSM=IDLE, bubble counter=0, stall_cnt=0. Outputs follow from that state:
//    stall_fe=0, bubble_ex=0, freeze_all=0. fwd_a/fwd_b are 0 unless a forwarding match is present.
//  Forwarding (combinational, 0 latency):
//    fwd_a = lowest k where src_regwrite[k] && src_rd[k]!=0 && src_rd[k]==ex_rs1, else 0.
//    fwd_a is forced 0 if ex_alu_src[0]=1 or ex_rs1=0. fwd_b applies the same rules to ex_rs2/ex_alu_src[1].
//    Priority is per operand and per source: rd!=0 is checked for each source individually.
//  Load-use hazard (hz): ex_is_load && ex_rd!=0 && ((id_rs_used[0]&&id_rs1==ex_rd) || (id_rs_used[1]&&id_rs2==ex_rd)).
//  FSM states IDLE, LDSTALL, MEMWAIT:
//    IDLE    : mem_busy -> MEMWAIT; else hz && !flush -> LDSTALL with cnt=LOAD_LAT-1, stall_fe=1, bubble_ex=1.
//    LDSTALL : stall_fe=1, bubble_ex=1; cnt==0 -> IDLE else cnt--.
//              mem_busy -> MEMWAIT, and the remaining count is kept; flush -> IDLE immediately.
//    MEMWAIT : freeze_all=1, stall_fe=1, bubble_ex=0.
//              !mem_busy -> LDSTALL if count was pending, else IDLE.
//  In IDLE the hazard outputs are combinational from hz, so the first bubble appears in the detect cycle.
//  Total bubbles per hazard = LOAD_LAT.
//  Simultaneous events: mem_busy outranks hz and flush. flush outranks hz. freeze_all holds fwd outputs valid.
//  stall_cnt increments each cycle stall_fe|freeze_all is 1 and saturates at all-ones (no wrap).
//  Async reset mid-stall returns to IDLE at once; outputs deassert without waiting for a clock edge.
// STRUCTURE
//  my_pkg additions:
//    typedef enum logic[1:0] {HZ_IDLE,HZ_LDSTALL,HZ_MEMWAIT} hz_state_e;
//    localparam NOFW = '0;
//    struct FU2_ctrl_i / FU2_ctrl_o bundling the ports above.
//  Sub-module fwd_src_sel: priority encoder (rs, alu_src bit, src_rd, src_regwrite) -> FSEL_W select.
//    Instantiated twice, for A and B.
//  Top level holds the FSM, the bubble counter and the perf counter.
// TESTING
//  1 src_rd={x3,x3}, src_regwrite=2'b11, ex_rs1=3, ex_alu_src=0 -> fwd_a=1 (youngest wins), fwd_b=0.
//  2 ex_rs2=0, src_rd[0]=0, src_regwrite=1 -> fwd_b=0.
//    ex_alu_src[1]=1 with a matching rs2 -> fwd_b=0.
//  3 LOAD_LAT=2, ex_is_load, ex_rd=5, id_rs2=5, id_rs_used=2'b10 -> stall_fe,bubble_ex high exactly 2 cycles, stall_cnt=2.
//  4 Same hazard with flush=1 in the detect cycle -> no stall, FSM stays IDLE.
//  5 LDSTALL cycle 1 then mem_busy for 3 cycles -> freeze_all 3 cycles, then 1 more bubble, stall_cnt=5.
//  6 rst_n low during MEMWAIT -> all stall outputs 0 immediately.
//    Force stall_cnt to all-ones minus 1, then stall 3 cycles -> stall_cnt holds all-ones.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding / hazard controller.
// Default-width bundles mirror the controller port list.
package fwd_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_IDLE,
        HZ_LDSTALL,
        HZ_MEMWAIT
    } hz_state_e;

    localparam int NOFW     = 0;
    localparam int DEF_AW   = 5;
    localparam int DEF_NSRC = 2;
    localparam int DEF_FSW  = $clog2(DEF_NSRC + 1);

    typedef struct packed {
        logic [DEF_AW-1:0]          id_rs1;
        logic [DEF_AW-1:0]          id_rs2;
        logic [1:0]                 id_rs_used;
        logic [DEF_AW-1:0]          ex_rs1;
        logic [DEF_AW-1:0]          ex_rs2;
        logic [1:0]                 ex_alu_src;
        logic [DEF_AW-1:0]          ex_rd;
        logic                       ex_is_load;
        logic [DEF_NSRC*DEF_AW-1:0] src_rd;
        logic [DEF_NSRC-1:0]        src_regwrite;
        logic                       mem_busy;
        logic                       flush;
    } fu2_ctrl_i_t;

    typedef struct packed {
        logic [DEF_FSW-1:0] fwd_a;
        logic [DEF_FSW-1:0] fwd_b;
        logic               stall_fe;
        logic               bubble_ex;
        logic               freeze_all;
    } fu2_ctrl_o_t;

endpackage

// File: rtl/fwd_hazard_ctrl_src_sel.sv
// Per-operand bypass select: lowest-index (youngest) writing source
// whose rd matches the operand register wins.
module fwd_src_sel
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int FSEL_W  = $clog2(NUM_SRC + 1)
) (
    input  logic [REG_AW-1:0]         rs,
    input  logic                      not_reg,
    input  logic [NUM_SRC*REG_AW-1:0] src_rd,
    input  logic [NUM_SRC-1:0]        src_regwrite,
    output logic [FSEL_W-1:0]         sel
);

    logic [REG_AW-1:0] w_rd;

    // Walk oldest to youngest so the youngest hit is written last.
    always_comb begin
        sel  = FSEL_W'(NOFW);
        w_rd = '0;
        if (!not_reg && rs != '0) begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                w_rd = src_rd[k*REG_AW +: REG_AW];
                if (src_regwrite[k] && w_rd != '0 && w_rd == rs)
                    sel = FSEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding, load-use bubble FSM, memory-wait freeze
// and saturating stall performance counter.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [REG_AW-1:0]                id_rs1,
    input  logic [REG_AW-1:0]                id_rs2,
    input  logic [1:0]                       id_rs_used,
    input  logic [REG_AW-1:0]                ex_rs1,
    input  logic [REG_AW-1:0]                ex_rs2,
    input  logic [1:0]                       ex_alu_src,
    input  logic [REG_AW-1:0]                ex_rd,
    input  logic                             ex_is_load,
    input  logic [NUM_SRC*REG_AW-1:0]        src_rd,
    input  logic [NUM_SRC-1:0]               src_regwrite,
    input  logic                             mem_busy,
    input  logic                             flush,
    output logic [$clog2(NUM_SRC+1)-1:0]     fwd_a,
    output logic [$clog2(NUM_SRC+1)-1:0]     fwd_b,
    output logic                             stall_fe,
    output logic                             bubble_ex,
    output logic                             freeze_all,
    output logic [CNT_W-1:0]                 stall_cnt
);

    localparam int         FSEL_W = $clog2(NUM_SRC + 1);
    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    hz_state_e          r_state;
    hz_state_e          w_nstate;
    hz_state_e          w_eff;
    logic [2:0]         r_cnt;
    logic [2:0]         w_ncnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_hz;
    logic               w_stall;
    logic               w_bub;
    logic               w_frz;

    fwd_src_sel #(
        .REG_AW (REG_AW),
        .NUM_SRC(NUM_SRC),
        .FSEL_W (FSEL_W)
    ) u_sel_a (
        .rs          (ex_rs1),
        .not_reg     (ex_alu_src[0]),
        .src_rd      (src_rd),
        .src_regwrite(src_regwrite),
        .sel         (fwd_a)
    );

    fwd_src_sel #(
        .REG_AW (REG_AW),
        .NUM_SRC(NUM_SRC),
        .FSEL_W (FSEL_W)
    ) u_sel_b (
        .rs          (ex_rs2),
        .not_reg     (ex_alu_src[1]),
        .src_rd      (src_rd),
        .src_regwrite(src_regwrite),
        .sel         (fwd_b)
    );

    assign w_hz = ex_is_load && ex_rd != '0 &&
                  ((id_rs_used[0] && id_rs1 == ex_rd) ||
                   (id_rs_used[1] && id_rs2 == ex_rd));

    // r_cnt holds bubbles still owed; the cycle memory becomes ready
    // resumes them immediately so a freeze never costs an extra slot.
    always_comb begin
        w_eff = r_state;
        if (r_state == HZ_MEMWAIT)
            w_eff = (r_cnt != '0) ? HZ_LDSTALL : HZ_IDLE;
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_stall  = 1'b0;
        w_bub    = 1'b0;
        w_frz    = 1'b0;
        if (mem_busy) begin
            w_nstate = HZ_MEMWAIT;
            w_stall  = 1'b1;
            w_frz    = 1'b1;
        end else begin
            unique case (w_eff)
                HZ_IDLE: begin
                    w_nstate = HZ_IDLE;
                    w_ncnt   = '0;
                    if (w_hz && !flush) begin
                        w_stall  = 1'b1;
                        w_bub    = 1'b1;
                        w_ncnt   = LAT_M1;
                        w_nstate = (LAT_M1 != '0) ? HZ_LDSTALL : HZ_IDLE;
                    end
                end
                HZ_LDSTALL: begin
                    if (flush) begin
                        w_nstate = HZ_IDLE;
                        w_ncnt   = '0;
                    end else begin
                        w_stall = 1'b1;
                        w_bub   = 1'b1;
                        if (r_cnt <= 3'd1) begin
                            w_nstate = HZ_IDLE;
                            w_ncnt   = '0;
                        end else begin
                            w_nstate = HZ_LDSTALL;
                            w_ncnt   = r_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    w_nstate = HZ_IDLE;
                    w_ncnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HZ_IDLE;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            if ((w_stall || w_frz) && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Gated by reset so a held mem_busy cannot keep the pipe stalled.
    assign stall_fe   = rst_n && w_stall;
    assign bubble_ex  = rst_n && w_bub;
    assign freeze_all = rst_n && w_frz;
    assign stall_cnt  = r_stall_cnt;

endmodule
